stopwatch_bcd: RTL and testbench

//  Centisecond stopwatch; consumer of the 1 kHz divider output (clkout of clk1kHz).
//  - Samples the divided 1 kHz square wave as a data input in the system clock domain.
//  - Counts in a 4-digit BCD display format SS.hh, range 00.00 to 99.99 s.
//  - Provides start/stop/clear control, a running flag and a sticky overflow flag.
//  - BCD output feeds the board seven-segment display stage.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/bcd_digit_counter.sv | 39 +++
 rtl/stopwatch_bcd.sv | 105 ++++++++++
 tb/tb_stopwatch_bcd.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch.
// Imported by the top level and the digit counter.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED
  } sw_state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal digit of the stopwatch display.
// Wraps 9 -> 0 and raises carry in the same cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       at_max;

  assign at_max = (digit_q == BCD_MAX);
  assign carry  = inc & at_max;
  assign digit  = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = 4'd0;
    end else if (inc) begin
      digit_d = at_max ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch SS.hh driven by a sampled 1 kHz tick.
// Edge detect, control FSM, prescaler and sticky overflow.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_LSB = 10,
  parameter int PRESCALE_W    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick_1khz,
  input  logic                    start_stop,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    running,
  output logic                    overflow
);

  localparam logic [PRESCALE_W-1:0] PRESC_TOP =
    PRESCALE_W'(TICKS_PER_LSB - 1);

  sw_state_t state_q;
  sw_state_t state_d;

  logic                  tick_q;
  logic                  rise;
  logic                  count_en;
  logic                  lsb_inc;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic                  running_q;
  logic                  ovf_q;
  logic                  ovf_d;
  logic [NUM_DIGITS:0]   cy;

  assign rise     = tick_1khz & ~tick_q;
  // Counting follows the current state, so a rise that
  // arrives with the pause pulse is still counted.
  assign count_en = (state_q == RUN) & rise & ~clear;
  assign lsb_inc  = count_en & (presc_q == PRESC_TOP);
  assign cy[0]    = lsb_inc;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSED;
        PAUSED:  state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = lsb_inc ? '0 : presc_q + 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (cy[NUM_DIGITS]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= 1'b1;
      presc_q   <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_1khz;
      presc_q   <= presc_d;
      running_q <= (state_d == RUN);
      ovf_q     <= ovf_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_counter u_dig (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .inc   (cy[i]),
      .digit (bcd[4*i +: 4]),
      .carry (cy[i+1])
    );
  end

  assign running  = running_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd with TICKS_PER_LSB=2.
// Reference keeps elapsed time as an integer count of hundredths.
module tb_stopwatch_bcd;

  logic        clk;
  logic        reset;
  logic        tick_1khz;
  logic        start_stop;
  logic        clear;
  logic [15:0] bcd;
  logic        running;
  logic        overflow;

  int checks;
  int errors;

  int m_cs;
  int m_pre;
  int m_state;
  bit m_ovf;
  bit m_tprev;

  stopwatch_bcd #(
    .TICKS_PER_LSB (2),
    .PRESCALE_W    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1khz  (tick_1khz),
    .start_stop (start_stop),
    .clear      (clear),
    .bcd        (bcd),
    .running    (running),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] model_bcd();
    logic [15:0] v;
    v[15:12] = 4'((m_cs / 1000) % 10);
    v[11:8]  = 4'((m_cs / 100) % 10);
    v[7:4]   = 4'((m_cs / 10) % 10);
    v[3:0]   = 4'(m_cs % 10);
    return v;
  endfunction

  function automatic bit bcd_legal(input logic [15:0] v);
    return (v[15:12] <= 9) && (v[11:8] <= 9) &&
           (v[7:4] <= 9) && (v[3:0] <= 9);
  endfunction

  // Model states: 0 idle, 1 run, 2 paused.
  task automatic model_step(input bit r, input bit t,
                            input bit s, input bit c);
    bit rise;
    rise = t && !m_tprev;
    if (r) begin
      m_cs = 0; m_pre = 0; m_state = 0;
      m_ovf = 0; m_tprev = 1;
    end else begin
      if (c) begin
        m_cs = 0; m_pre = 0; m_state = 0; m_ovf = 0;
      end else begin
        if (m_state == 1 && rise) begin
          if (m_pre == 1) begin
            m_pre = 0;
            m_cs = m_cs + 1;
            if (m_cs == 10000) begin
              m_cs = 0;
              m_ovf = 1;
            end
          end else begin
            m_pre = m_pre + 1;
          end
        end
        if (s) m_state = (m_state == 1) ? 2 : 1;
      end
      m_tprev = t;
    end
  endtask

  task automatic cyc(input bit r, input bit t,
                     input bit s, input bit c);
    reset = r; tick_1khz = t; start_stop = s; clear = c;
    @(posedge clk);
    model_step(r, t, s, c);
    #1;
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  task automatic rise_once();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    checks++;
    if (bcd !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals bcd=%h run=%b ovf=%b exp 0000/0/0",
               bcd, running, overflow);
    end
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    checks++;
    if (bcd !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release bcd=%h run=%b exp 0000/0",
               bcd, running);
    end
  endtask

  task automatic test_start_count();
    cyc(0, 0, 1, 0);
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL start_running got=%b exp=1", running);
    end
    rise_once();
    rise_once();
    checks++;
    if (bcd !== 16'h0001 || bcd !== model_bcd()) begin
      errors++;
      $display("FAIL first_lsb bcd=%h exp=0001", bcd);
    end
  endtask

  task automatic test_carry();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      rise_once();
      checks++;
      if (bcd !== model_bcd()) begin
        errors++;
        $display("FAIL carry_step%0d bcd=%h exp=%h", i, bcd, model_bcd());
      end
    end
    checks++;
    if (bcd !== 16'h0010) begin
      errors++;
      $display("FAIL carry_tenths bcd=%h exp=0010", bcd);
    end
  endtask

  task automatic test_overflow();
    int bad;
    bad = 0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 19998; i++) begin
      rise_once();
      if (!bcd_legal(bcd)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL illegal_digits count=%0d exp=0", bad);
    end
    checks++;
    if (bcd !== 16'h9999 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL preload bcd=%h ovf=%b exp 9999/0", bcd, overflow);
    end
    rise_once();
    rise_once();
    checks++;
    if (bcd !== 16'h0000 || overflow !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap bcd=%h ovf=%b run=%b exp 0000/1/1",
               bcd, overflow, running);
    end
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    checks++;
    if (overflow !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky ovf=%b run=%b exp 1/1", overflow, running);
    end
  endtask

  task automatic test_clear_wins();
    for (int i = 0; i < 84; i++) rise_once();
    checks++;
    if (bcd !== 16'h0042 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL at_0042 bcd=%h ovf=%b exp 0042/1", bcd, overflow);
    end
    cyc(0, 0, 1, 1);
    checks++;
    if (bcd !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins bcd=%h ovf=%b run=%b exp 0000/0/0",
               bcd, overflow, running);
    end
    rise_once();
    rise_once();
    checks++;
    if (bcd !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold bcd=%h run=%b exp 0000/0", bcd, running);
    end
  endtask

  task automatic test_pause_resume();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) rise_once();
    checks++;
    if (bcd !== 16'h0005) begin
      errors++;
      $display("FAIL pre_pause bcd=%h exp=0005", bcd);
    end
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      rise_once();
      checks++;
      if (bcd !== 16'h0005 || running !== 1'b0) begin
        errors++;
        $display("FAIL paused_hold%0d bcd=%h run=%b exp 0005/0",
                 i, bcd, running);
      end
    end
    cyc(0, 0, 1, 0);
    rise_once();
    checks++;
    if (bcd !== 16'h0006 || running !== 1'b1) begin
      errors++;
      $display("FAIL resume bcd=%h run=%b exp 0006/1", bcd, running);
    end
  endtask

  task automatic test_edge_cases();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 0);
    rise_once();
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    checks++;
    if (bcd !== 16'h0001 || running !== 1'b0) begin
      errors++;
      $display("FAIL rise_on_pause bcd=%h run=%b exp 0001/0",
               bcd, running);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    rise_once();
    checks++;
    if (bcd !== 16'h0001) begin
      errors++;
      $display("FAIL rise_on_resume bcd=%h exp=0001", bcd);
    end
    rise_once();
    checks++;
    if (bcd !== 16'h0002 || running !== 1'b1) begin
      errors++;
      $display("FAIL after_resume bcd=%h run=%b exp 0002/1",
               bcd, running);
    end
  endtask

  task automatic test_random();
    bit r, t, s, c;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 11) == 0);
      t = $urandom_range(0, 1) == 1;
      cyc(r, t, s, c);
      checks++;
      if (bcd !== model_bcd() || running !== (m_state == 1) ||
          overflow !== m_ovf || !bcd_legal(bcd)) begin
        errors++;
        $display("FAIL rand%0d bcd=%h run=%b ovf=%b exp %h/%b/%b",
                 i, bcd, running, overflow, model_bcd(),
                 (m_state == 1), m_ovf);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_cs = 0; m_pre = 0; m_state = 0; m_ovf = 0; m_tprev = 1;
    reset = 1'b1; tick_1khz = 1'b1;
    start_stop = 1'b0; clear = 1'b0;
    test_reset();
    test_start_count();
    test_carry();
    test_overflow();
    test_clear_wins();
    test_pause_resume();
    test_edge_cases();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
